// File: rtl/tx_access_sched.sv
// Per-frame transmit access scheduler: queue selection, tx_start issue, ACK window, retry/CW escalation.
// Define TX_SCHED_STRICT_PRIO_EN for strict lowest-index-first queue selection instead of round-robin.
module tx_access_sched #(
   parameter logic [3:0] CW_EXP_MIN  = 4'd4,
   parameter logic [3:0] CW_EXP_MAX  = 4'd10,
   parameter logic [3:0] RETRY_LIMIT = 4'd7
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       tsf_pulse_1M,
   input  logic [3:0] q_req,
   input  logic [3:0] q_need_ack,
   input  logic [3:0] slice_en,
   input  logic       backoff_done,
   input  logic       ch_idle,
   input  logic       phy_tx_done,
   input  logic       ack_valid,
   input  logic [9:0] ack_timeout_top,
   output logic [3:0] cw_exp,
   output logic       tx_start,
   output logic [1:0] tx_qid,
   output logic [3:0] q_done,
   output logic [3:0] q_drop,
   output logic [3:0] retry_cnt,
   output logic [2:0] sched_state
);

   typedef enum logic [2:0] {
      S_IDLE         = 3'd0,
      S_WAIT_BACKOFF = 3'd1,
      S_TX           = 3'd2,
      S_WAIT_ACK     = 3'd3
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] tx_qid_q, tx_qid_d;
   logic [1:0] last_qid_q, last_qid_d;
   logic       need_ack_q, need_ack_d;
   logic       armed_q, armed_d;
   logic [9:0] ack_timer_q, ack_timer_d;
   logic [3:0] retry_cnt_q, retry_cnt_d;
   logic [3:0] cw_exp_q, cw_exp_d;
   logic       tx_start_q, tx_start_d;
   logic [3:0] q_done_q, q_done_d;
   logic [3:0] q_drop_q, q_drop_d;

   logic [3:0] elig;
   logic [1:0] pick;
   logic       succ, fail;

   assign elig = q_req & slice_en;

`ifdef TX_SCHED_STRICT_PRIO_EN
   // Walk downwards so the lowest eligible index is the last (winning) assignment.
   always_comb begin
      pick = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (elig[i]) pick = i[1:0];
      end
   end
`else
   logic [1:0] idx;
   // Walk from the farthest offset to last_qid+1 so the nearest eligible queue wins.
   always_comb begin
      pick = 2'd0;
      idx  = 2'd0;
      for (int i = 4; i >= 1; i--) begin
         idx = last_qid_q + i[1:0];
         if (elig[idx]) pick = idx;
      end
   end
`endif

   always_comb begin
      state_d     = state_q;
      tx_qid_d    = tx_qid_q;
      last_qid_d  = last_qid_q;
      need_ack_d  = need_ack_q;
      armed_d     = armed_q;
      ack_timer_d = ack_timer_q;
      retry_cnt_d = retry_cnt_q;
      cw_exp_d    = cw_exp_q;
      tx_start_d  = 1'b0;
      q_done_d    = 4'd0;
      q_drop_d    = 4'd0;
      succ        = 1'b0;
      fail        = 1'b0;

      // A fresh low phase of backoff_done is required before the next access.
      if (!backoff_done) armed_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (|elig) begin
               tx_qid_d   = pick;
               need_ack_d = q_need_ack[pick];
               state_d    = S_WAIT_BACKOFF;
            end
         end
         S_WAIT_BACKOFF: begin
            if (!elig[tx_qid_q]) begin
               state_d = S_IDLE;
            end else if (armed_q && backoff_done && ch_idle) begin
               tx_start_d = 1'b1;
               armed_d    = 1'b0;
               state_d    = S_TX;
            end
         end
         S_TX: begin
            if (phy_tx_done) begin
               if (need_ack_q) begin
                  ack_timer_d = ack_timeout_top;
                  state_d     = S_WAIT_ACK;
               end else begin
                  succ = 1'b1;
               end
            end
         end
         S_WAIT_ACK: begin
            if (ack_valid) begin
               succ = 1'b1;
            end else if (ack_timer_q == 10'd0) begin
               fail = 1'b1;
            end else if (tsf_pulse_1M) begin
               ack_timer_d = ack_timer_q - 10'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (succ || (fail && (retry_cnt_q == RETRY_LIMIT))) begin
         if (succ) q_done_d = 4'b0001 << tx_qid_q;
         else      q_drop_d = 4'b0001 << tx_qid_q;
         retry_cnt_d = 4'd0;
         cw_exp_d    = CW_EXP_MIN;
         last_qid_d  = tx_qid_q;
         state_d     = S_IDLE;
      end else if (fail) begin
         retry_cnt_d = retry_cnt_q + 4'd1;
         cw_exp_d    = (cw_exp_q >= CW_EXP_MAX) ? CW_EXP_MAX : cw_exp_q + 4'd1;
         state_d     = S_WAIT_BACKOFF;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         tx_qid_q    <= 2'd0;
         last_qid_q  <= 2'd3;
         need_ack_q  <= 1'b0;
         armed_q     <= 1'b1;
         ack_timer_q <= 10'd0;
         retry_cnt_q <= 4'd0;
         cw_exp_q    <= CW_EXP_MIN;
         tx_start_q  <= 1'b0;
         q_done_q    <= 4'd0;
         q_drop_q    <= 4'd0;
      end else begin
         state_q     <= state_d;
         tx_qid_q    <= tx_qid_d;
         last_qid_q  <= last_qid_d;
         need_ack_q  <= need_ack_d;
         armed_q     <= armed_d;
         ack_timer_q <= ack_timer_d;
         retry_cnt_q <= retry_cnt_d;
         cw_exp_q    <= cw_exp_d;
         tx_start_q  <= tx_start_d;
         q_done_q    <= q_done_d;
         q_drop_q    <= q_drop_d;
      end
   end

   assign cw_exp      = cw_exp_q;
   assign tx_start    = tx_start_q;
   assign tx_qid      = tx_qid_q;
   assign q_done      = q_done_q;
   assign q_drop      = q_drop_q;
   assign retry_cnt   = retry_cnt_q;
   assign sched_state = state_q;

endmodule

// File: doc/tx_access_sched.md
# tx_access_sched

Per-frame transmit access scheduler sitting above the CSMA/CA backoff engine.
- Selects one of four TX queues and waits for the backoff engine to report the medium won.
- Issues a single `tx_start` to the PHY TX path.
- Tracks the ACK window and drives retry and contention-window (CW) exponent escalation back into the backoff engine's `cw_min` input.
- One frame in flight at a time.

## Interface
- `CW_EXP_MIN`, 4: CW exponent after reset or success.
- `CW_EXP_MAX`, 10: saturation value of the CW exponent.
- `RETRY_LIMIT`, 7: retransmissions allowed before a frame is dropped.
- `clk` in 1: system clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `tsf_pulse_1M` in 1: 1 µs tick, one cycle wide.
- `q_req` in 4: queue has a frame pending (level).
- `q_need_ack` in 4: head frame of that queue expects an ACK.
- `slice_en` in 4: time-slice enable per queue (level).
- `backoff_done` in 1: backoff engine in RUN with timer 0 (level).
- `ch_idle` in 1: final channel-idle (CCA and NAV) level.
- `phy_tx_done` in 1: PHY finished the last sample (strobe).
- `ack_valid` in 1: ACK addressed to us received with good FCS (strobe).
- `ack_timeout_top` in 10: ACK window in µs.
- `cw_exp` out 4: CW exponent, wired to backoff-engine `cw_min`.
- `tx_start` out 1: start-transmit strobe.
- `tx_qid` out 2: queue being served.
- `q_done` out 4: one-hot success strobe.
- `q_drop` out 4: one-hot drop strobe.
- `retry_cnt` out 4: retries used on the current frame.
- `sched_state` out 3: current state, for debug.

## Operation
- **States:**
  - IDLE=0, WAIT_BACKOFF=1, TX=2, WAIT_ACK=3.
  - Success and fail are one-cycle actions taken on the transition out of TX or WAIT_ACK; they are not states.
- **Eligibility:** `elig = q_req & slice_en`.
- **IDLE:**
  - If `elig != 0`, pick a queue round-robin, starting from `last_qid+1` mod 4.
  - Latch it into `tx_qid` and latch `q_need_ack[tx_qid]` into `need_ack`.
  - Go to WAIT_BACKOFF.
- **WAIT_BACKOFF:**
  - If `elig[tx_qid]==0`, go to IDLE; `retry_cnt` and `cw_exp` are kept.
  - Else if `armed && backoff_done && ch_idle`: pulse `tx_start`, clear `armed`, go to TX.
- **armed:**
  - Cleared when `tx_start` pulses.
  - Set on any cycle where `backoff_done==0`.
  - Purpose: a stale `backoff_done` level left over from the previous access cannot start a second frame.
- **TX:**
  - Wait for `phy_tx_done`.
  - If `need_ack`, load `ack_timer = ack_timeout_top` and go to WAIT_ACK.
  - Otherwise take the success action.
- **WAIT_ACK:**
  - `ack_timer` decrements on `tsf_pulse_1M` and holds at 0.
  - `ack_valid` → success action.
  - `ack_timer==0` with no `ack_valid` → fail action.
  - `ack_valid` in the same cycle the timer reaches 0 counts as success.
- **Success action:**
  - `q_done[tx_qid]` strobes.
  - `retry_cnt = 0`, `cw_exp = CW_EXP_MIN`, `last_qid = tx_qid`.
  - Go to IDLE.
- **Fail action:**
  - If `retry_cnt == RETRY_LIMIT`: same as success, except `q_drop[tx_qid]` strobes instead of `q_done`.
  - Else: `retry_cnt += 1`, `cw_exp = min(cw_exp+1, CW_EXP_MAX)`, go to WAIT_BACKOFF with the same `tx_qid`.
- **Ignored inputs:**
  - `ack_valid` outside WAIT_ACK.
  - `phy_tx_done` outside TX.
- **Widths:** `ack_timer` is 10 bits. `ack_timeout_top==0` produces a fail on the first WAIT_ACK cycle.
- **Reset values:**
  - `cw_exp = CW_EXP_MIN`.
  - `tx_start = 0`, `tx_qid = 0`, `q_done = 0`, `q_drop = 0`, `retry_cnt = 0`.
  - `sched_state = IDLE`, `last_qid = 3`, `armed = 1`.

## Timing
- All outputs are registered.
- IDLE → WAIT_BACKOFF: 1 cycle after `elig` rises.
- `tx_start`: rises 1 cycle after the cycle in which `armed && backoff_done && ch_idle`; exactly 1 cycle wide.
- `q_done` / `q_drop`: 1 cycle wide, asserted the cycle after the deciding strobe or timer expiry.
- `cw_exp`: updates in the same cycle as the `q_done`/`q_drop` strobe or the retry transition.
- A new `tx_start` needs `backoff_done` to fall and rise again.
- Reset asserted mid-frame: all state clears immediately (asynchronous). No `q_done`/`q_drop` is emitted for the aborted frame.

## Configuration
- `TX_SCHED_STRICT_PRIO_EN` defined: queue selection is strict priority, lowest index first; `last_qid` is not used for selection.
- Undefined (default): round-robin as described in Operation.

## Test plan
- `q_req=4'b0101`, `slice_en=4'hF`, `need_ack=0`, `backoff_done` raised twice → `tx_qid` 0 then 2; `q_done=0001` then `0100`.
- `q_req=1`, `need_ack=1`, `ack_timeout_top=44`, no ACK for 8 attempts → `cw_exp` 4,5,6,…,10,10; after 8 `tx_start` strobes `q_drop=0001`, then `retry_cnt=0`, `cw_exp=4`.
- `ack_valid` strobed in the same cycle the ACK timer reaches 0 → `q_done` strobes, no retry.
- `backoff_done` held high across `phy_tx_done` of a no-ACK frame with a second frame pending → no second `tx_start` until `backoff_done` toggles low then high.
- `slice_en[0]` dropped while in WAIT_BACKOFF with `retry_cnt=2` → state goes to IDLE; `retry_cnt` stays 2; no `tx_start`.
- With `TX_SCHED_STRICT_PRIO_EN` defined, `q_req=4'b1010` held → queue 1 served repeatedly and queue 3 is never granted.
